multi_port_line_memory: RTL
===========================

MULTI_PORT_LINE_MEMORY -- requirements
Module: multi_port_line_memory

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, bits per word.
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per line, power of two, 1..8.
REQ-003 SHALL have parameter MEM_WORDS, default 256, array depth in words, power of two, multiple of LINE_WORDS.
REQ-004 SHALL have parameter NUM_CH, default 2, independent request channels, 1..4.
REQ-005 SHALL have parameter LATENCY, default 4, cycles from accept to response, 2..7.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_read, input, NUM_CH, per-channel read request.
REQ-009 SHALL have port req_write, input, NUM_CH, per-channel write request.
REQ-010 SHALL have port req_addr, input, NUM_CH*WORD_SIZE, per-channel word address.
REQ-011 SHALL have port req_wdata, input, NUM_CH*LINE_WORDS*WORD_SIZE, write line; word i in bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
REQ-012 SHALL have port req_wmask, input, NUM_CH*LINE_WORDS, per-word write enable; present only with MEM_WMASK_EN.
REQ-013 SHALL have port req_ready, output, NUM_CH, channel idle and able to accept.
REQ-014 SHALL have port rsp_valid, output, NUM_CH, one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata, output, NUM_CH*LINE_WORDS*WORD_SIZE, read line, same word packing as wdata.

Function
REQ-016 SHALL accept a request on channel c at a rising edge where (req_read[c]|req_write[c]) && req_ready[c], capturing op, address, wdata and mask into channel registers.
REQ-017 SHALL drive req_ready[c] high only while channel c has no operation in flight, including the cycle rsp_valid[c] is high, so back-to-back accept every LATENCY cycles is possible.
REQ-018 SHALL pulse rsp_valid[c] high for exactly one cycle, beginning LATENCY-1 edges after the accept edge (LATENCY=4: accept at edge 0, valid high between edges 3 and 4), for both reads and writes.
REQ-019 SHALL form the line base address as req_addr with its low log2(LINE_WORDS) bits cleared, taken modulo MEM_WORDS (out-of-range addresses wrap, no error).
REQ-020 SHALL, on read completion edge, load rsp_rdata[c] with the full line; rsp_rdata[c] SHALL hold until the next read completion on c.
REQ-021 SHALL, on write completion edge, update the line from the channel's own captured write data only; writes never alter rsp_rdata.
REQ-022 SHALL treat req_read and req_write both high as a write.
REQ-023 SHALL return pre-edge contents when a read and a write to the same line complete at the same edge.
REQ-024 SHALL resolve writes from several channels to the same word at the same edge in favour of the lowest channel index.
REQ-025 SHALL ignore request inputs while req_ready[c] is low (no queuing, no overwrite of captured request).

Reset
REQ-026 SHALL, while reset_n low, force req_ready to all-ones, rsp_valid to 0, rsp_rdata to 0, and clear all latency counters and captured request state.
REQ-027 SHALL discard an in-flight operation on reset assertion; a pending write SHALL NOT modify the array.
REQ-028 SHALL NOT reset or initialise array contents.

Configuration
REQ-029 SHALL support macro MEM_WMASK_EN: defined -> req_wmask present, only words with mask bit 1 written; undefined -> port absent, every write updates all LINE_WORDS words.

Structure
REQ-030 SHALL take default WORD_SIZE, LINE_WORDS, MEM_WORDS, the line-offset width constant and the op-code enum (IDLE/READ/WRITE) from shared package mem_pkg.
REQ-031 SHALL instantiate sub-module mem_channel_ctrl once per channel (capture registers, latency counter, ready/valid generation); array and write resolution stay in the top.

Verification
REQ-032 Write line 0x9023,0x0001,0xFFFF,0x0000 to addr 0x00 on ch0, then read addr 0x02 -> rsp_rdata[0] equals that line, rsp_valid high exactly one cycle, 3 edges after each accept (LATENCY=4).
REQ-033 ch0 write 0x1111x4 and ch1 write 0x2222x4 to addr 0x40 at same edge -> read returns 0x1111x4.
REQ-034 ch0 read addr 0x20 while ch1 writes 0xAAAAx4 to 0x20 completing same edge -> ch0 gets old data; later read gets 0xAAAA.
REQ-035 Assert reset_n low at cycle 2 of a write of 0x5555x4 to 0x10 -> ready high, valid 0, line 0x10 unchanged.
REQ-036 MEM_WMASK_EN, mask 4'b0101, data 0xBEEFx4 on line holding 0x0000x4 -> read returns 0xBEEF,0x0000,0xBEEF,0x0000 (word0 first); addr 0x104 with MEM_WORDS=256 hits line 0x04.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg                                                                    |
// | Shared defaults, line-offset helper and op-code enum for the line memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

   localparam int DEF_WORD_SIZE  = 16;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_MEM_WORDS  = 256;

   function automatic int line_ofs_w(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 0;
   endfunction

   localparam int LINE_OFS_W = line_ofs_w(DEF_LINE_WORDS);

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

endpackage
`default_nettype wire

// File: rtl/mem_channel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_channel_ctrl                                                           |
// | One request channel: request capture, latency counter, ready/valid.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_channel_ctrl
   import mem_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_WORD_SIZE,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int ADDR_W     = $clog2(DEF_MEM_WORDS),
   parameter int LINE_OFS   = LINE_OFS_W,
   parameter int LATENCY    = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             req_read_i,
   input  logic                             req_write_i,
   input  logic [WORD_SIZE-1:0]             req_addr_i,
   input  logic [LINE_WORDS*WORD_SIZE-1:0]  req_wdata_i,
   input  logic [LINE_WORDS-1:0]            req_wmask_i,
   output logic                             req_ready_o,
   output logic                             rsp_valid_o,
   output logic                             done_o,
   output op_e                              op_o,
   output logic [ADDR_W-1:0]                base_o,
   output logic [LINE_WORDS*WORD_SIZE-1:0]  wdata_o,
   output logic [LINE_WORDS-1:0]            wmask_o
);

   localparam logic [2:0]        c_lat_load  = 3'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] c_base_mask = ~ADDR_W'((1 << LINE_OFS) - 1);

   op_e                            op_q, op_d;
   logic [2:0]                     cnt_q, cnt_d;
   logic [ADDR_W-1:0]              base_q, base_d;
   logic [LINE_WORDS*WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [LINE_WORDS-1:0]          wmask_q, wmask_d;
   logic                           rsp_valid_q;
   logic                           w_accept;
   logic                           w_done;

   assign w_accept = (op_q == OP_IDLE) && (req_read_i || req_write_i);
   // Counter is loaded with LATENCY-1 so the completion edge lands LATENCY-1 edges after accept.
   assign w_done   = (op_q != OP_IDLE) && (cnt_q == 3'd1);

   always_comb begin
      op_d    = op_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      if (w_accept) begin
         op_d    = req_write_i ? OP_WRITE : OP_READ;
         cnt_d   = c_lat_load;
         base_d  = req_addr_i[ADDR_W-1:0] & c_base_mask;
         wdata_d = req_wdata_i;
         wmask_d = req_wmask_i;
      end else if (w_done) begin
         op_d  = OP_IDLE;
         cnt_d = '0;
      end else if (op_q != OP_IDLE) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q        <= OP_IDLE;
         cnt_q       <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         rsp_valid_q <= w_done;
      end
   end

   generate
      if (WORD_SIZE > ADDR_W) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^req_addr_i[WORD_SIZE-1:ADDR_W];
      end
   endgenerate

   assign req_ready_o = (op_q == OP_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign done_o      = w_done;
   assign op_o        = op_q;
   assign base_o      = base_q;
   assign wdata_o     = wdata_q;
   assign wmask_o     = wmask_q;

endmodule
`default_nettype wire

// File: rtl/multi_port_line_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_port_line_memory                                                     |
// | Multi-channel fixed-latency line memory; MEM_WMASK_EN adds per-word masks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_port_line_memory
   import mem_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_WORD_SIZE,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int MEM_WORDS  = DEF_MEM_WORDS,
   parameter int NUM_CH     = 2,
   parameter int LATENCY    = 4
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_CH-1:0]                      req_read,
   input  logic [NUM_CH-1:0]                      req_write,
   input  logic [NUM_CH*WORD_SIZE-1:0]            req_addr,
   input  logic [NUM_CH*LINE_WORDS*WORD_SIZE-1:0] req_wdata,
`ifdef MEM_WMASK_EN
   input  logic [NUM_CH*LINE_WORDS-1:0]           req_wmask,
`endif
   output logic [NUM_CH-1:0]                      req_ready,
   output logic [NUM_CH-1:0]                      rsp_valid,
   output logic [NUM_CH*LINE_WORDS*WORD_SIZE-1:0] rsp_rdata
);

   localparam int c_aw = $clog2(MEM_WORDS);
   localparam int c_lb = LINE_WORDS * WORD_SIZE;

   logic [WORD_SIZE-1:0]  mem_q [MEM_WORDS];

   logic [NUM_CH-1:0]     w_done;
   logic [NUM_CH-1:0]     w_wr;
   op_e                   w_op    [NUM_CH];
   logic [c_aw-1:0]       w_base  [NUM_CH];
   logic [c_lb-1:0]       w_wdata [NUM_CH];
   logic [LINE_WORDS-1:0] w_wmask [NUM_CH];
   logic [LINE_WORDS-1:0] w_wmask_in [NUM_CH];

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         logic [c_lb-1:0] w_line;
         logic [c_lb-1:0] rdata_q;

`ifdef MEM_WMASK_EN
         assign w_wmask_in[c] = req_wmask[c*LINE_WORDS +: LINE_WORDS];
`else
         assign w_wmask_in[c] = '1;
`endif

         mem_channel_ctrl #(
            .WORD_SIZE  (WORD_SIZE),
            .LINE_WORDS (LINE_WORDS),
            .ADDR_W     (c_aw),
            .LINE_OFS   (line_ofs_w(LINE_WORDS)),
            .LATENCY    (LATENCY)
         ) u_ctrl (
            .clk         (clk),
            .reset_n     (reset_n),
            .req_read_i  (req_read[c]),
            .req_write_i (req_write[c]),
            .req_addr_i  (req_addr[c*WORD_SIZE +: WORD_SIZE]),
            .req_wdata_i (req_wdata[c*c_lb +: c_lb]),
            .req_wmask_i (w_wmask_in[c]),
            .req_ready_o (req_ready[c]),
            .rsp_valid_o (rsp_valid[c]),
            .done_o      (w_done[c]),
            .op_o        (w_op[c]),
            .base_o      (w_base[c]),
            .wdata_o     (w_wdata[c]),
            .wmask_o     (w_wmask[c])
         );

         assign w_wr[c] = w_done[c] && (w_op[c] == OP_WRITE);

         always_comb begin
            w_line = '0;
            for (int w = 0; w < LINE_WORDS; w++) begin
               w_line[w*WORD_SIZE +: WORD_SIZE] = mem_q[w_base[c] | c_aw'(w)];
            end
         end

         // Array reads are pre-edge, so a same-edge write to the line is not visible here.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rdata_q <= '0;
            end else if (w_done[c] && (w_op[c] == OP_READ)) begin
               rdata_q <= w_line;
            end
         end

         assign rsp_rdata[c*c_lb +: c_lb] = rdata_q;
      end
   endgenerate

   // Highest channel is applied first so the lowest index wins on a shared word.
   always_ff @(posedge clk) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (w_wr[c]) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
               if (w_wmask[c][w]) begin
                  mem_q[w_base[c] | c_aw'(w)] <= w_wdata[c][w*WORD_SIZE +: WORD_SIZE];
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
